// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with one-cycle read latency.
// Define MEM_ARB_GNT_CNT_EN to add saturating per-requester grant counters (gnt_cnt0/gnt_cnt1).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_GNT_CNT_EN
  ,
  output logic [15:0]           gnt_cnt0,
  output logic [15:0]           gnt_cnt1
`endif
);

  logic                  last_gnt;   // 1 = requester 1 was granted most recently
  logic                  rd_pend0;
  logic                  rd_pend1;
  logic                  any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || last_gnt)) gnt0 = 1'b1;
      else if (req1)                   gnt1 = 1'b1;
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign rdata     = mem_rdata;

  // Read return pipeline: grant -> rd_pend (with mem_rd_en) -> rvalid (with mem_rdata).
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt  <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      rd_pend0  <= 1'b0;
      rd_pend1  <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      if (any_gnt) begin
        last_gnt  <= gnt1;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      mem_wr_en <= any_gnt & sel_we;
      mem_rd_en <= any_gnt & ~sel_we;
      rd_pend0  <= gnt0 & ~we0;
      rd_pend1  <= gnt1 & ~we1;
      rvalid0   <= rd_pend0;
      rvalid1   <= rd_pend1;
    end
  end

`ifdef MEM_ARB_GNT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt1 && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule
